serial_fir_sequencer: RTL and testbench
=======================================

Name: serial_fir_sequencer

Overview:
- Timing and handshake controller for the shared serial FIR filter bank: 16 band filters reading one 119-tap sample delay pipeline, each with one multiply-accumulate per clock over 60 cycles per input sample.
- Accepts input samples with a valid/ready handshake and produces the pipeline shift strobe.
- Drives the folded-symmetric tap address pair, the accumulator clear/enable controls and the bank output-valid strobe.
- Sits between the sample source and the filter bank; it replaces the free-running phase counter inside the filters.

Parameters:
- NUM_CYCLES, 60: MAC cycles per sample, equal to the number of folded tap pairs plus the centre tap.
- NUM_TAPS, 119: delay pipeline length; must equal 2*NUM_CYCLES-1.
- CNT_W, 6: counter and tap-address width; 2**CNT_W must be at least NUM_TAPS/2+1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_enable  in  1  global enable; when low all state is frozen
- run_en  in  1  level; 1 = process samples, 0 = stop at the next frame boundary
- in_valid  in  1  source presents a sample
- in_ready  out  1  sequencer can accept a sample this cycle
- shift_en  out  1  shift the delay pipeline and load filter_in; equals in_valid & in_ready & clk_enable (combinational)
- cur_count  out  CNT_W  current MAC cycle index, 0..NUM_CYCLES-1
- tap_addr_lo  out  CNT_W  equals cur_count
- tap_addr_hi  out  7  equals NUM_TAPS-1-cur_count
- center_tap  out  1  cur_count==NUM_CYCLES-1 (lo==hi, single product, no pre-add)
- acc_clear  out  1  load the product instead of accumulating (first MAC cycle)
- acc_enable  out  1  a MAC cycle is valid
- out_valid  out  1  one-cycle pulse: accumulators hold a completed output
- overrun  out  1  sticky: a sample was offered while in_ready=0
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cur_count=0, out_valid=0, overrun=0. All combinational outputs decode to 0 except tap_addr_hi=118.
- States: IDLE, WAIT, RUN. Registered transitions happen only when clk_enable=1.
- IDLE:
  - in_ready=0.
  - run_en=1 -> WAIT.
- WAIT:
  - in_ready=1, acc_enable=0.
  - Accepted sample -> RUN with cur_count=0.
  - run_en=0 with no accept -> IDLE.
- RUN:
  - acc_enable=1.
  - acc_clear=1 when cur_count=0.
  - cur_count increments by 1 each enabled cycle.
  - in_ready=1 only when cur_count=NUM_CYCLES-1 and run_en=1.
- Frame end (RUN, cur_count=NUM_CYCLES-1):
  - out_valid=1 on the next enabled cycle, regardless of which branch below is taken.
  - Sample accepted -> cur_count wraps to 0, stay in RUN. This gives back-to-back frames with no bubble.
  - No sample and run_en=1 -> WAIT.
  - run_en=0 -> IDLE; in_ready stays 0.
- run_en dropping mid-frame: the frame completes and its out_valid still pulses. Frames are never truncated.
- Latency:
  - First sample accepted at edge T -> acc_clear at T+1.
  - Last MAC (centre tap) at T+60.
  - out_valid at T+61.
- clk_enable=0: state, counter and registered outputs hold. shift_en=0. out_valid stays at its value and is counted as one pulse.
- Overrun:
  - Set on any enabled cycle with in_valid=1 and in_ready=0, excluding IDLE.
  - Cleared by overrun_clr; if set and clear coincide, set wins.
- Asynchronous reset mid-frame: return to IDLE immediately. The partial accumulation is discarded and no out_valid is produced.

Test Plan:
- Reset release, run_en=1, in_valid=1 held -> shift_en pulses every 60 cycles; cur_count sequence 0..59,0; out_valid first pulse 61 cycles after first accept; no overrun.
- Single sample, then in_valid=0 -> at cur_count=59: center_tap=1, tap_addr_lo=tap_addr_hi=59; at count 0: tap_addr_hi=118; next cycle out_valid=1 and state WAIT with in_ready=1.
- in_valid=1 at cur_count=30 -> overrun=1 and stays 1; overrun_clr with no new violation -> 0; clear coincident with a violation -> stays 1.
- run_en dropped at cur_count=10 -> counting continues to 59; out_valid pulses; in_ready stays 0 at frame end; state IDLE.
- clk_enable low for 5 cycles at cur_count=20 -> cur_count holds 20, shift_en=0; frame end delayed by exactly 5 cycles.
- reset asserted at cur_count=40 -> immediately cur_count=0, acc_enable=0, out_valid=0; no out_valid after release until a new sample completes a full frame.

Source files
------------

// File: rtl/serial_fir_sequencer.sv
// rtl/serial_fir_sequencer.sv - sample handshake, MAC phase counter and tap addressing for the serial FIR bank
module serial_fir_sequencer #(
  parameter int NUM_CYCLES = 60,
  parameter int NUM_TAPS   = 119,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             run_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic [CNT_W-1:0] cur_count,
  output logic [CNT_W-1:0] tap_addr_lo,
  output logic [6:0]       tap_addr_hi,
  output logic             center_tap,
  output logic             acc_clear,
  output logic             acc_enable,
  output logic             out_valid,
  output logic             overrun,
  input  logic             overrun_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CYCLES - 1);
  localparam logic [6:0]       TOP_TAP  = 7'(NUM_TAPS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             out_valid_q;
  logic             overrun_q;
  logic             last_cycle;
  logic             accept;

  assign last_cycle  = (state_q == S_RUN) && (count_q == LAST_CNT);
  assign in_ready    = (state_q == S_WAIT) || (last_cycle && run_en);
  assign accept      = in_valid && in_ready;
  assign shift_en    = accept && clk_enable;

  // Folded-symmetric pair: lo walks up from tap 0, hi walks down from the last tap.
  assign cur_count   = count_q;
  assign tap_addr_lo = count_q;
  assign tap_addr_hi = TOP_TAP - 7'(count_q);
  assign center_tap  = (count_q == LAST_CNT);
  assign acc_enable  = (state_q == S_RUN);
  assign acc_clear   = (state_q == S_RUN) && (count_q == '0);
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (run_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (accept) begin
          state_d = S_RUN;
          count_d = '0;
        end else if (!run_en) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (count_q == LAST_CNT) begin
          // Counter always parks at 0 so the next frame or idle state starts clean.
          count_d = '0;
          if (accept)      state_d = S_RUN;
          else if (run_en) state_d = S_WAIT;
          else             state_d = S_IDLE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= last_cycle;
      // A new violation outranks a coincident clear.
      if (in_valid && !in_ready && (state_q != S_IDLE)) overrun_q <= 1'b1;
      else if (overrun_clr)                            overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_fir_sequencer.sv
// tb/tb_serial_fir_sequencer.sv - scoreboard bench for serial_fir_sequencer
module tb_serial_fir_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clk_enable = 1'b0;
  logic       run_en = 1'b0;
  logic       in_valid = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       in_ready;
  logic       shift_en;
  logic [5:0] cur_count;
  logic [5:0] tap_addr_lo;
  logic [6:0] tap_addr_hi;
  logic       center_tap;
  logic       acc_clear;
  logic       acc_enable;
  logic       out_valid;
  logic       overrun;

  serial_fir_sequencer #(.NUM_CYCLES(60), .NUM_TAPS(119), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .run_en      (run_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .shift_en    (shift_en),
    .cur_count   (cur_count),
    .tap_addr_lo (tap_addr_lo),
    .tap_addr_hi (tap_addr_hi),
    .center_tap  (center_tap),
    .acc_clear   (acc_clear),
    .acc_enable  (acc_enable),
    .out_valid   (out_valid),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   mon_exp;
  logic ov_prev = 1'b0;
  int   a;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected out_valid rise times are queued at accept; compared when the pulse appears.
  always @(negedge clock) begin
    if (out_valid && !ov_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_valid_unexpected cyc=%0d required no pulse", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cyc != mon_exp) begin
          errors++;
          $display("FAIL out_valid_time got cyc=%0d required cyc=%0d", cyc, mon_exp);
        end
      end
    end
    ov_prev <= out_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d required bench completion", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run_en = 1'b0;
    in_valid = 1'b0;
    overrun_clr = 1'b0;
    clk_enable = 1'b1;
    ticks(2);
    chk("rst_count", cur_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc_enable", acc_enable, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_center_tap", center_tap, 0);
    chk("rst_tap_hi", tap_addr_hi, 118);
    reset = 1'b1;
  endtask

  // From IDLE: one cycle to WAIT, accept on the next edge. stall < 0 means no pulse is expected.
  task automatic start_frame(input bit hold, input int stall, output int acc_cyc);
    run_en = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("wait_in_ready", in_ready, 1);
    chk("wait_shift_en", shift_en, 1);
    chk("wait_acc_enable", acc_enable, 0);
    tick();
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
    chk("first_acc_clear", acc_clear, 1);
    chk("first_count", cur_count, 0);
    chk("first_tap_hi", tap_addr_hi, 118);
    if (stall >= 0) exp_q.push_back(acc_cyc + 60 + stall);
  endtask

  initial begin
    // Back-to-back frames with in_valid held high
    do_reset();
    start_frame(1'b1, 0, a);
    for (int i = 1; i < 60; i++) begin
      tick();
      chk("b2b_count", cur_count, i);
      chk("b2b_shift_en", shift_en, (i == 59) ? 1 : 0);
    end
    tick();
    exp_q.push_back(a + 120);
    chk("b2b_wrap_count", cur_count, 0);
    chk("b2b_wrap_clear", acc_clear, 1);
    chk("b2b_out_valid", out_valid, 1);
    ticks(59);
    chk("b2b_f2_last", cur_count, 59);
    in_valid = 1'b0;
    tick();
    chk("b2b_end_wait_ready", in_ready, 1);
    chk("b2b_end_acc_enable", acc_enable, 0);
    ticks(3);

    // Single sample: tap addressing and frame end into WAIT
    do_reset();
    start_frame(1'b0, 0, a);
    chk("single_tap_lo0", tap_addr_lo, 0);
    ticks(58);
    chk("single_center58", center_tap, 0);
    tick();
    chk("single_center59", center_tap, 1);
    chk("single_tap_lo59", tap_addr_lo, 59);
    chk("single_tap_hi59", tap_addr_hi, 59);
    chk("single_ready59", in_ready, 1);
    tick();
    chk("single_out_valid", out_valid, 1);
    chk("single_wait_ready", in_ready, 1);
    chk("single_wait_acc_en", acc_enable, 0);
    chk("single_overrun", overrun, 0);
    ticks(2);

    // Overrun set, hold, clear, and set winning over clear
    do_reset();
    start_frame(1'b0, 0, a);
    ticks(30);
    chk("ovr_count30", cur_count, 30);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ovr_set", overrun, 1);
    tick();
    chk("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    overrun_clr = 1'b1;
    in_valid = 1'b1;
    tick();
    overrun_clr = 1'b0;
    in_valid = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    chk("ovr_count34", cur_count, 34);
    ticks(30);

    // run_en dropped mid-frame: frame completes, then IDLE
    do_reset();
    start_frame(1'b0, 0, a);
    ticks(10);
    run_en = 1'b0;
    ticks(49);
    chk("drop_count59", cur_count, 59);
    chk("drop_ready59", in_ready, 0);
    tick();
    chk("drop_out_valid", out_valid, 1);
    chk("drop_acc_enable", acc_enable, 0);
    chk("drop_ready_idle", in_ready, 0);
    in_valid = 1'b1;
    tick();
    chk("drop_idle_ready", in_ready, 0);
    chk("drop_idle_no_ovr", overrun, 0);
    in_valid = 1'b0;
    ticks(2);

    // clk_enable low for 5 cycles at count 20
    do_reset();
    start_frame(1'b0, 5, a);
    ticks(20);
    chk("stall_count20", cur_count, 20);
    clk_enable = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_count", cur_count, 20);
      chk("stall_shift_en", shift_en, 0);
    end
    clk_enable = 1'b1;
    in_valid = 1'b0;
    chk("stall_no_ovr", overrun, 0);
    ticks(39);
    chk("stall_count59", cur_count, 59);
    ticks(3);

    // Asynchronous reset mid-frame discards the frame
    do_reset();
    start_frame(1'b0, -1, a);
    ticks(40);
    chk("arst_count40", cur_count, 40);
    #1 reset = 1'b0;
    #1;
    chk("arst_count", cur_count, 0);
    chk("arst_acc_enable", acc_enable, 0);
    chk("arst_out_valid", out_valid, 0);
    ticks(2);
    reset = 1'b1;
    run_en = 1'b1;
    ticks(80);
    run_en = 1'b0;
    tick();
    start_frame(1'b0, 0, a);
    ticks(62);

    ticks(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
